// File: rtl/balance_ledger.sv
// rtl/balance_ledger.sv - single-request deposit/withdraw ledger with overflow, funds and optional withdrawal-limit checks
// Optional feature: define LEDGER_WDRAW_LIMIT_EN to enable the cumulative withdrawal limit.
module balance_ledger #(
  parameter logic [31:0] MAX_BALANCE  = 32'd99999999,
  parameter logic [31:0] INIT_BALANCE = 32'd0,
  parameter logic [31:0] WDRAW_LIMIT  = 32'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_amount,
  output logic        resp_valid,
  output logic [1:0]  resp_status,
  output logic [31:0] balance,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_COMMIT, S_REJECT, S_RESP} state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_FUNDS = 2'b01;
  localparam logic [1:0] ST_OVF   = 2'b10;
  localparam logic [1:0] ST_LIMIT = 2'b11;

  state_t      state_q, state_d;
  logic        check_phase_q;
  logic        op_q;
  logic [31:0] amt_q;
  logic [31:0] cand_q, cand_d;
  logic [1:0]  status_q, status_d;
  logic [32:0] sum33;
  logic [32:0] wsum33;
  logic [31:0] wdraw_base;

`ifdef LEDGER_WDRAW_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
  logic [31:0] withdrawn_total;
  assign wdraw_base = withdrawn_total;
`else
  localparam bit LIMIT_EN = 1'b0;
  assign wdraw_base = '0;
`endif

  assign sum33  = {1'b0, balance} + {1'b0, amt_q};
  assign wsum33 = {1'b0, wdraw_base} + {1'b0, amt_q};

  // Funds shortfall outranks the withdrawal limit.
  always_comb begin
    status_d = ST_OK;
    cand_d   = op_q ? (balance - amt_q) : sum33[31:0];
    if (!op_q) begin
      if (sum33 > {1'b0, MAX_BALANCE}) status_d = ST_OVF;
    end else if (amt_q > balance) begin
      status_d = ST_FUNDS;
    end else if (LIMIT_EN && (wsum33 > {1'b0, WDRAW_LIMIT})) begin
      status_d = ST_LIMIT;
    end
  end

  // CHECK spends two cycles: first registers candidate/status, second branches on them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_CHECK;
      S_CHECK:  if (check_phase_q) state_d = (status_q == ST_OK) ? S_COMMIT : S_REJECT;
      S_COMMIT: state_d = S_RESP;
      S_REJECT: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      check_phase_q <= 1'b0;
      op_q          <= 1'b0;
      amt_q         <= '0;
      cand_q        <= '0;
      status_q      <= ST_OK;
      resp_status   <= ST_OK;
      balance       <= INIT_BALANCE;
`ifdef LEDGER_WDRAW_LIMIT_EN
      withdrawn_total <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          check_phase_q <= 1'b0;
          if (req_valid) begin
            op_q  <= req_op;
            amt_q <= req_amount;
          end
        end
        S_CHECK: begin
          check_phase_q <= 1'b1;
          if (!check_phase_q) begin
            cand_q   <= cand_d;
            status_q <= status_d;
          end
        end
        S_COMMIT: begin
          balance     <= cand_q;
          resp_status <= status_q;
`ifdef LEDGER_WDRAW_LIMIT_EN
          if (op_q) withdrawn_total <= wsum33[32] ? 32'hFFFF_FFFF : wsum33[31:0];
`endif
        end
        S_REJECT: resp_status <= status_q;
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_balance_ledger.sv
// tb/tb_balance_ledger.sv - randomized self-checking bench for balance_ledger against a behavioural ledger model
module tb_balance_ledger;

  localparam longint MAX_BAL  = 99999999;
  localparam longint INIT_BAL = 0;
  localparam longint LIMIT    = 1000;
  localparam longint SAT32    = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_amount;
  logic        resp_valid;
  logic [1:0]  resp_status;
  logic [31:0] balance;
  logic        busy;

  int     n_checks = 0;
  int     n_errors = 0;
  longint m_bal;
  longint m_wt;

  balance_ledger dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_amount(req_amount), .resp_valid(resp_valid),
    .resp_status(resp_status), .balance(balance), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ledger rules applied with plain integer arithmetic.
  function automatic int model_apply(input logic op, input longint amt);
    if (!op) begin
      if (m_bal + amt > MAX_BAL) return 2;
      m_bal = m_bal + amt;
      return 0;
    end
    if (amt > m_bal) return 1;
`ifdef LEDGER_WDRAW_LIMIT_EN
    if (m_wt + amt > LIMIT) return 3;
    m_wt = (m_wt + amt > SAT32) ? SAT32 : m_wt + amt;
`endif
    m_bal = m_bal - amt;
    return 0;
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that re-enters IDLE.
  task automatic txn(input logic op, input logic [31:0] amt, input bit scramble);
    int st;
    st = model_apply(op, longint'(amt));
    check("ready_before", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_amount = amt;
    @(posedge clk); #1;
    check("busy_after_accept", busy, 1);
    check("ready_low_busy", req_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      if (scramble) begin
        req_amount = $urandom;
        req_op     = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (k == 3) begin
        check("resp_valid_pulse", resp_valid, 1);
        check("resp_status", resp_status, 64'(st));
        check("balance_at_resp", balance, 64'(m_bal));
      end else begin
        check("resp_valid_quiet", resp_valid, 0);
      end
      if (k == 4) begin
        check("ready_back", req_ready, 1);
        check("status_held", resp_status, 64'(st));
        check("balance_after", balance, 64'(m_bal));
      end
    end
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_status", resp_status, 0);
    check("rst_balance", balance, 64'(INIT_BAL));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1);
    m_bal = INIT_BAL;
    m_wt  = 0;
  endtask

  initial begin
    int     sel;
    logic   op;
    longint a;
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_amount = '0;
    m_bal = INIT_BAL; m_wt = 0;
    @(posedge clk); #1;
    do_reset();

    txn(1'b0, 32'd250, 1'b0);
    txn(1'b1, 32'd300, 1'b0);
    txn(1'b1, 32'd250, 1'b0);
    txn(1'b0, 32'd99999990, 1'b0);
    txn(1'b0, 32'd10, 1'b0);
    txn(1'b0, 32'd9, 1'b0);
    txn(1'b0, 32'd0, 1'b0);
    txn(1'b1, 32'd0, 1'b0);
    txn(1'b1, 32'd999, 1'b0);

    // Reset while the deposit sits in COMMIT.
    req_valid = 1'b1; req_op = 1'b0; req_amount = 32'd100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_balance", balance, 64'(INIT_BAL));
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    check("mid_rst_no_resp", resp_valid, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 1);
    m_bal = INIT_BAL; m_wt = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_rst_no_resp", resp_valid, 0);
      check("post_rst_balance", balance, 64'(INIT_BAL));
    end

`ifdef LEDGER_WDRAW_LIMIT_EN
    do_reset();
    txn(1'b0, 32'd5000, 1'b0);
    txn(1'b1, 32'd600, 1'b0);
    txn(1'b1, 32'd401, 1'b0);
    txn(1'b1, 32'd400, 1'b0);
    txn(1'b1, 32'd9000, 1'b0);
`endif

    txn(1'b0, 32'd4000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      op  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = longint'($urandom_range(0, 3000));
      else if (sel == 6) a = MAX_BAL - m_bal;
      else if (sel == 7) a = m_bal;
      else if (sel == 8) a = longint'($urandom);
      else               a = m_bal + 1;
      txn(op, a[31:0], 1'b1);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
